// File: rtl/dmem_pkg.sv
// Shared request/response types and helpers for the data-memory responder.
// Also supplies the stall-injection LFSR constants used when DMEM_STALL_INJECT_EN is defined.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_TAG_W  = 4;

    localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] DMEM_LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic                     we;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
        logic [DMEM_DATA_W/8-1:0] be;
        logic [DMEM_TAG_W-1:0]    tag;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_DATA_W-1:0] rdata;
        logic [DMEM_TAG_W-1:0]  tag;
        logic                   err;
    } dmem_rsp_t;

    // Byte address to word index; the full width is kept so out-of-range addresses stay visible.
    function automatic logic [DMEM_ADDR_W-1:0] word_index(input logic [DMEM_ADDR_W-1:0] addr);
        return {2'b00, addr[DMEM_ADDR_W-1:2]};
    endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// First-word-fall-through response queue of dmem_rsp_t entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dmem_rsp_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  dmem_rsp_t push_data_i,
    input  logic      pop_i,
    output dmem_rsp_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = $clog2(DEPTH);

    dmem_rsp_t     mem_q [DEPTH];
    logic [PW:0]   wr_q, wr_d;
    logic [PW:0]   rd_q, rd_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_i);
    // Payload reads as zero when nothing is queued, so outputs are clean after reset.
    assign head_o    = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

    // Next-state pointer arithmetic.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok_s) begin
            wr_d = wr_q + (PW+1)'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + (PW+1)'(1);
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; contents are only observed through a valid pointer.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q[PW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Tagged data-memory responder: fixed-latency in-order responses with credit backpressure.
// Optional DMEM_STALL_INJECT_EN adds LFSR-driven pseudo-random request stalls.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4,
    parameter int TAG_W       = DMEM_TAG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [TAG_W-1:0]    req_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CW    = $clog2(QDEPTH) + 1;

    dmem_req_t          req_s;
    dmem_rsp_t          entry_s;
    dmem_rsp_t          push_data_s;
    dmem_rsp_t          head_s;
    logic [ADDR_W-1:0]  wi_s;
    logic [IDX_W-1:0]   idx_s;
    logic               err_s;
    logic               accept_s;
    logic               pop_s;
    logic               push_s;
    logic               stall_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];

    assign req_s    = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be, tag: req_tag};
    assign wi_s     = word_index(req_s.addr);
    assign idx_s    = wi_s[IDX_W-1:0];
    assign err_s    = (req_s.addr[1:0] != 2'b00) || (wi_s >= ADDR_W'(DEPTH_WORDS));
    assign req_ready = reset && !stall_s && (cnt_q < CW'(QDEPTH));
    assign accept_s = req_valid && req_ready;
    assign pop_s    = rsp_valid && rsp_ready;

`ifdef DMEM_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR step.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? DMEM_LFSR_TAPS : 16'h0000);
    end

    // LFSR free-runs every cycle from the seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= DMEM_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_s = (lfsr_q[1:0] == 2'b00);
`else
    assign stall_s = 1'b0;
`endif

    // Response payload captured at the accept edge; writes and errors carry zero data.
    always_comb begin
        entry_s       = '0;
        entry_s.tag   = req_s.tag;
        entry_s.err   = err_s;
        if (req_s.we || err_s) begin
            entry_s.rdata = {DATA_W{1'b0}};
        end else begin
            entry_s.rdata = mem_q[idx_s];
        end
    end

    // Outstanding count covers pipe plus queue, so the queue can never overflow.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_s && !pop_s) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept_s && pop_s) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Word array with per-lane writes; erroring writes leave it untouched.
    always_ff @(posedge clk) begin
        if (accept_s && req_s.we && !err_s) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (req_s.be[b]) begin
                    mem_q[idx_s][8*b +: 8] <= req_s.wdata[8*b +: 8];
                end
            end
        end
    end

    // The queue write is the last latency stage, so LATENCY-1 registered stages precede it.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign push_s      = accept_s;
            assign push_data_s = entry_s;
        end else begin : g_pipe
            logic [LATENCY-2:0] v_q;
            dmem_rsp_t          d_q [LATENCY-1];

            // Delay pipe shift.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_q <= '0;
                    for (int i = 0; i < LATENCY-1; i++) begin
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= accept_s;
                    d_q[0] <= entry_s;
                    for (int i = 1; i < LATENCY-1; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign push_s      = v_q[LATENCY-2];
            assign push_data_s = d_q[LATENCY-2];
        end
    endgenerate

    dmem_rsp_fifo #(
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign rsp_valid = !fifo_empty_s;
    assign rsp_rdata = head_s.rdata;
    assign rsp_tag   = head_s.tag;
    assign rsp_err   = head_s.err;

    logic unused_s;
    assign unused_s = fifo_full_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder; DMEM_STALL_INJECT_EN relaxes exact-cycle ready checks.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic [3:0]  req_tag = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_tag;
    logic        rsp_err;

    dmem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  tag;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    rec_t        mon_q[$];
    int          acc_q[$];
    rec_t        exp_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;
    logic        rnd_bp = 1'b0;
    vec_t        vecs[15];
    logic [31:0] model[16];

    // Response and accept monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) mon_q.push_back('{rsp_tag, rsp_rdata, rsp_err, cyc});
        if (reset && req_valid && req_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [3:0] tg);
        logic acc;
        acc = 1'b0;
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_tag = tg; req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); acc = req_ready;
            step();
            if (rnd_bp) rsp_ready = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_vec++; n_mis++;
            $display("FAIL send_timeout: tag %h not accepted in 100 cycles", tg);
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200; i++) begin
            if (mon_q.size() >= n) break;
            step();
        end
        chk("rsp_count", 64'(mon_q.size()), 64'(n));
    endtask

    // Offer nreq reads back-to-back with rsp_ready low, then drain and check order.
    task automatic burst(input int nreq, input logic [3:0] tag0);
        int   n_acc;
        logic acc;
        rec_t r;
        n_acc = 0;
        rsp_ready = 1'b0; mon_q.delete();
        req_we = 1'b0; req_be = 4'h0; req_wdata = 32'h0;
        req_addr = 32'h100; req_tag = tag0; req_valid = 1'b1;
        for (int i = 0; i < nreq; i++) begin
            @(negedge clk); acc = req_ready;
            step();
            if (acc) begin
                n_acc++;
                req_addr = 32'h100 + 32'(4 * (n_acc % 4));
                req_tag  = tag0 + 4'(n_acc);
            end
        end
        req_valid = 1'b0;
`ifndef DMEM_STALL_INJECT_EN
        chk("burst_accepts", 64'(n_acc), 64'd4);
`endif
        chk("full_ready_low", 64'(req_ready), 64'(n_acc == 4 ? 0 : 1));
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_head_tag", 64'(rsp_tag), 64'(tag0));
        step(); step();
        chk("bp_stable", {rsp_valid, rsp_tag, rsp_rdata}, {1'b1, tag0, 32'hB0000000});
        rsp_ready = 1'b1;
        step();
`ifndef DMEM_STALL_INJECT_EN
        chk("ready_after_pop", 64'(req_ready), 64'd1);
`endif
        wait_rsp(n_acc);
        for (int k = 0; k < n_acc && mon_q.size() > 0; k++) begin
            r = mon_q.pop_front();
            chk("drain_order", {r.tag, r.err, r.rdata}, {tag0 + 4'(k), 1'b0, 32'hB0000000 + 32'(k % 4)});
        end
    endtask

    initial begin
        rec_t        r;
        rec_t        e;
        int          a;
        int          k;
        logic [31:0] d;
        logic [3:0]  be;
        logic [3:0]  tg;

        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    4'h1, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0,    4'h2, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF,    4'h3, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'b0101, 4'h4, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'h0,    4'h5, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF,    4'h6, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h3,        32'h0,        4'h0,    4'h7, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF,    4'h8, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,        4'h0,    4'h9, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFC,      32'h0BADF00D, 4'hF,    4'hA, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 32'hFFC,      32'h77775555, 4'b0011, 4'hB, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'hFFC,      32'h0,        4'h0,    4'hC, 32'h0BAD5555, 1'b0};
        vecs[12] = '{1'b1, 32'h22,       32'hFFFFFFFF, 4'hF,    4'hD, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h20,       32'h0,        4'h0,    4'hE, 32'h11BB33DD, 1'b0};
        vecs[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0,    4'hF, 32'h0,        1'b1};

        // Reset held for two cycles.
        step(); step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_outputs", {rsp_valid, rsp_err, rsp_tag, rsp_rdata}, 64'd0);
        @(negedge clk); reset = 1'b1; #1;
        chk("idle_ready", 64'(req_ready), 64'd1);
        step(); step();
        chk("idle_valid", 64'(rsp_valid), 64'd0);

        // Table-driven single requests with latency check.
        mon_q.delete(); acc_q.delete();
        for (int i = 0; i < 15; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].tag);
            wait_rsp(1);
            if (mon_q.size() > 0 && acc_q.size() > 0) begin
                r = mon_q.pop_front();
                a = acc_q.pop_front();
                chk("vec_rsp", {r.tag, r.err, r.rdata}, {vecs[i].tag, vecs[i].exp_err, vecs[i].exp_rdata});
                chk("vec_latency", 64'(r.cyc - a), 64'd2);
            end
            mon_q.delete(); acc_q.delete();
        end

        // Write then read on consecutive cycles.
        send(1'b1, 32'h40, 32'h13579BDF, 4'hF, 4'h1);
        send(1'b0, 32'h40, 32'h0, 4'h0, 4'h2);
        wait_rsp(2);
        if (mon_q.size() >= 2 && acc_q.size() >= 2) begin
            chk("b2b_first", {mon_q[0].tag, mon_q[0].rdata}, {4'h1, 32'h0});
            chk("b2b_second", {mon_q[1].tag, mon_q[1].rdata}, {4'h2, 32'h13579BDF});
            chk("b2b_lat", 64'(mon_q[0].cyc - acc_q[0]), 64'd2);
`ifndef DMEM_STALL_INJECT_EN
            chk("b2b_gap", 64'(mon_q[1].cyc - mon_q[0].cyc), 64'd1);
`endif
        end

        // Preload burst words, then backpressure/full.
        for (int i = 0; i < 4; i++) send(1'b1, 32'h100 + 32'(4 * i), 32'hB0000000 + 32'(i), 4'hF, 4'(i));
        step(); step(); step();
        burst(6, 4'h0);

        // Reset with reads in flight.
        rsp_ready = 1'b0;
        send(1'b0, 32'h100, 32'h0, 4'h0, 4'h5);
        send(1'b0, 32'h104, 32'h0, 4'h0, 4'h6);
        send(1'b0, 32'h108, 32'h0, 4'h0, 4'h7);
        step(); step(); step();
        chk("pre_reset_valid", 64'(rsp_valid), 64'd1);
        #2 reset = 1'b0; #1;
        chk("async_rst_out", {rsp_valid, rsp_err, rsp_tag, rsp_rdata}, 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        step();
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        burst(6, 4'h8);
        step(); step(); step();
        chk("no_stale_rsp", 64'(mon_q.size()), 64'd0);

        // Random traffic against a word model, random response backpressure.
        mon_q.delete(); exp_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model[i] = d;
            exp_q.push_back('{4'(i), 32'h0, 1'b0, 0});
            send(1'b1, 32'h200 + 32'(4 * i), d, 4'hF, 4'(i));
        end
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 15);
            tg = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                d  = $urandom;
                be = 4'($urandom_range(0, 15));
                for (int b = 0; b < 4; b++) if (be[b]) model[k][8*b +: 8] = d[8*b +: 8];
                exp_q.push_back('{tg, 32'h0, 1'b0, 0});
                send(1'b1, 32'h200 + 32'(4 * k), d, be, tg);
            end else begin
                exp_q.push_back('{tg, model[k], 1'b0, 0});
                send(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h0, tg);
            end
        end
        rnd_bp = 1'b0; rsp_ready = 1'b1;
        wait_rsp(216);
        while (mon_q.size() > 0 && exp_q.size() > 0) begin
            r = mon_q.pop_front();
            e = exp_q.pop_front();
            chk("rand_rsp", {r.tag, r.err, r.rdata}, {e.tag, e.err, e.rdata});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder sitting on the load/store side of the `pipelined` core. It is the target end of the core's memory request interface.
- Accepts tagged read/write requests over a valid/ready handshake and services them against an internal word array.
- Returns tagged responses after a fixed latency, in request order, through a bounded response queue, with credit-based backpressure.
- Used by the processor top and by core-level benches as the memory model.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; must be 32 (byte enables are DATA_W/8).
- DEPTH_WORDS, 1024, number of words in the array; power of two.
- LATENCY, 2, cycles from request accept to earliest rsp_valid; range 1..8.
- QDEPTH, 4, maximum outstanding requests and response queue depth; power of two, minimum 2.
- TAG_W, 4, request/response tag width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes.
- req_tag  in  TAG_W  tag echoed in the response.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_err  out  1  misaligned or out-of-range request.

Behaviour:
- Reset (reset low, asynchronous): req_ready=0 while asserted; rsp_valid=0, rsp_rdata=0, rsp_tag=0, rsp_err=0. Outstanding count, delay pipe valids and queue pointers clear. A mid-operation reset discards all in-flight requests.
- The memory array is not reset; contents are undefined until written. The bench must not read unwritten words.
- Accept: occurs when req_valid && req_ready at a rising edge. req_ready = (outstanding < QDEPTH), registered-free and independent of req_valid.
- Outstanding counter:
  - +1 on accept.
  - −1 on response handshake (rsp_valid && rsp_ready).
  - Unchanged when both occur in the same cycle.
  - Never exceeds QDEPTH, so the queue cannot overflow.
- Error checks: err = (req_addr[1:0] != 0) or (word index >= DEPTH_WORDS). An erroring write does not modify the array. An erroring read returns rdata=0.
- Writes: the array is updated at the accept edge, per byte lane where req_be[i]=1. Writes always return a response with rdata=0.
- Reads: the array is read at the accept edge, so a read accepted the cycle after a write sees the new data. The result travels a LATENCY-stage shift pipe of {valid, tag, err, rdata}.
- Pipe exit: enqueues into the QDEPTH-entry FIFO. rsp_* shows the FIFO head (first-word-fall-through).
  - Request accepted at edge N → rsp_valid high in the cycle after edge N+LATENCY−1 at earliest, i.e. visible LATENCY cycles after accept.
  - Responses stay in acceptance order.
- Backpressure: rsp_valid and the rsp_* payload stay stable while rsp_ready=0.
- Simultaneous enqueue and dequeue: both take effect, including on an empty FIFO (the newly enqueued entry appears the next cycle).
- Pointers wrap modulo QDEPTH; full/empty use an extra pointer bit.

Optional Feature:
- DMEM_STALL_INJECT_EN defined: a 16-bit Galois LFSR (seed 16'hACE1, taps 0xB400) advances every cycle and clears on reset. req_ready is additionally forced low whenever lfsr[1:0]==2'b00. This stresses the core's stall paths.
- Undefined: req_ready depends only on the outstanding count. No LFSR is instantiated.

Decomposition:
- dmem_pkg holds:
  - typedef dmem_req_t {we, addr, wdata, be, tag}.
  - typedef dmem_rsp_t {rdata, tag, err}.
  - Constant DMEM_LFSR_SEED.
  - Function word_index(addr).
- Sub-module dmem_rsp_fifo: a parameterized FWFT FIFO of dmem_rsp_t, with push/pop/full/empty and asynchronous active-low reset.

Test Plan:
- Reset then idle: reset low for 2 cycles → req_ready=0 during reset. After release, req_ready=1 and rsp_valid=0 with no requests.
- Write/read: write addr 0x10, wdata 0xDEADBEEF, be 4'hF, tag 1, then read 0x10 tag 2, rsp_ready=1 → rsp tag1 rdata 0 err 0 at accept+2. Rsp tag2 rdata 0xDEADBEEF follows one cycle later.
- Byte enables: write 0x11223344 to 0x20 with be 4'hF, then write 0xAABBCCDD with be 4'b0101, then read → rdata 0x11BB33DD.
- Errors: read addr 0x03 → err=1, rdata=0. Write to word index 1024 → err=1 and memory unchanged (verified by a read of 0x0 returning the prior value).
- Backpressure/full: hold rsp_ready=0 and issue 6 back-to-back reads → exactly 4 accepted, then req_ready=0. Release rsp_ready → tags drain in order 0..3 and req_ready returns high in the cycle after the first pop.
- Reset mid-flight: 3 reads outstanding, pulse reset low → rsp_valid drops immediately (asynchronous) and the outstanding count is 0 after release. With DMEM_STALL_INJECT_EN defined, 200 random requests all complete in order with correct data.
